// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit                                                              |
// | Iterative shift-add multiplier / restoring divider owning MIPS HI and LO.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            mthi,
    input  logic            mtlo,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [1:0]        op_q,     op_d;
    logic [XLEN-1:0]   opnd_q,   opnd_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              qsign_q,  qsign_d;
    logic              rsign_q,  rsign_d;
    logic              dz_q,     dz_d;
    logic [XLEN-1:0]   raw1_q,   raw1_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;
    logic              done_q,   done_d;
    logic              dzp_q,    dzp_d;

    logic              w_signed_op;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_signed_op = ~op[0];
    assign w_mag1 = (w_signed_op && data1[XLEN-1]) ? -data1 : data1;
    assign w_mag2 = (w_signed_op && data2[XLEN-1]) ? -data2 : data2;

    // Multiply: low half of acc holds the remaining multiplier bits.
    assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits being shifted into quotient}.
    assign w_rem_shift = acc_q[2*XLEN-1:XLEN-1];
    assign w_diff      = w_rem_shift - {1'b0, opnd_q};
    assign w_div_next  = w_diff[XLEN] ? {w_rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {w_diff[XLEN-1:0],      acc_q[XLEN-2:0], 1'b1};

    assign w_prod = qsign_q ? -acc_q : acc_q;
    assign w_quot = qsign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem  = rsign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        count_d = count_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        raw1_d  = raw1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzp_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    qsign_d = w_signed_op & (data1[XLEN-1] ^ data2[XLEN-1]);
                    rsign_d = w_signed_op & data1[XLEN-1];
                    raw1_d  = data1;
                    count_d = '0;
                    dz_d    = op[1] && (data2 == '0);
                    if (op[1]) begin
                        opnd_d = w_mag2;
                        acc_d  = {{XLEN{1'b0}}, w_mag1};
                    end else begin
                        opnd_d = w_mag1;
                        acc_d  = {{XLEN{1'b0}}, w_mag2};
                    end
                    state_d = (op[1] && (data2 == '0)) ? S_FIN : S_CALC;
                end else begin
                    if (mthi) hi_d = data1;
                    if (mtlo) lo_d = data1;
                end
            end
            S_CALC: begin
                count_d = count_q + CW'(1);
                acc_d   = op_q[1] ? w_div_next : w_mul_next;
                if (count_q == CW'(XLEN - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                // Divide-by-zero idles one extra cycle here so its write lands two edges after start.
                if (dz_q && (count_q == '0)) begin
                    count_d = CW'(1);
                end else begin
                    if (dz_q) begin
                        hi_d = raw1_q;
                        lo_d = '1;
                    end else if (op_q[1]) begin
                        hi_d = w_rem;
                        lo_d = w_quot;
                    end else begin
                        hi_d = w_prod[2*XLEN-1:XLEN];
                        lo_d = w_prod[XLEN-1:0];
                    end
                    done_d  = 1'b1;
                    dzp_d   = dz_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            raw1_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dzp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            raw1_q  <= raw1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzp_q   <= dzp_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dzp_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_div_unit                                                           |
// | Scoreboard bench: directed HI/LO operations checked on every done pulse.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mult_div_unit;

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    mult_div_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .data1       (data1),
        .data2       (data2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && div_by_zero && !done) begin
            tests++;
            fails++;
            $display("FAIL dz_without_done: got 1 expected 0");
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("result_dz", 64'(div_by_zero), 64'(e.dz));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        op    = o;
        data1 = d1;
        data2 = d2;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
    endtask

    // Returns edges from the start edge to the edge raising done, and busy-high samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
            if (lat > 100) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
                break;
            end
        end
    endtask

    int          lat;
    int          bcnt;
    logic [31:0] hi_before;
    logic [31:0] lo_before;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        data1 = '0;
        data2 = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz",   64'(div_by_zero), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed multiply latency and busy window
        @(negedge clk);
        issue(C_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(bcnt), 64'd33);
        check("busy_low_on_done", 64'(busy), 64'd0);

        // Back-to-back start in the done cycle
        issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check("b2b_accepted", 64'(busy), 64'd1);
        wait_done(lat, bcnt);

        @(negedge clk);
        issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(lat, bcnt);
        issue(C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done(lat, bcnt);
        issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done(lat, bcnt);
        issue(C_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        wait_done(lat, bcnt);
        issue(C_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        wait_done(lat, bcnt);

        // Divide by zero, unsigned and signed
        @(negedge clk);
        issue(C_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bcnt);
        check("dz_latency", 64'(lat), 64'd2);
        check("dz_pulse_with_done", 64'(div_by_zero), 64'd1);
        @(posedge clk);
        #1;
        check("dz_pulse_clears", 64'({done, div_by_zero}), 64'd0);
        @(negedge clk);
        issue(C_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bcnt);

        // Start, mthi and mtlo while busy are ignored
        hi_before = hi;
        lo_before = lo;
        @(negedge clk);
        issue(C_MULT, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = C_DIVU;
        data1 = 32'd55;
        data2 = 32'd3;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("busy_mtlo_ignored", 64'(lo), 64'(lo_before));
        check("busy_mthi_ignored", 64'(hi), 64'(hi_before));
        wait_done(lat, bcnt);
        check("ignored_start_latency", 64'(lat), 64'd23);
        repeat (40) @(posedge clk);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        issue(C_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;

        // mthi/mtlo in IDLE, then start takes priority over them
        @(negedge clk);
        data1 = 32'hA5A5_A5A5;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_write", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        check("mtlo_write", 64'(lo), 64'h0000_0000_A5A5_A5A5);
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        issue(C_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        check("start_prio_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        check("start_prio_lo", 64'(lo), 64'h0000_0000_A5A5_A5A5);
        mthi = 1'b0;
        mtlo = 1'b0;
        wait_done(lat, bcnt);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle HI/LO unit for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU on the same operand buses (data1, data2) that feed the single-cycle ALU.
- Owns the architectural HI/LO registers and exposes them for MFHI/MFLO.
- Uses a start/busy/done handshake so the pipeline stalls while the operation iterates.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- data1  input  XLEN  multiplicand/dividend; also MTHI/MTLO write data
- data2  input  XLEN  multiplier/divisor; sampled with start
- mthi  input  1  write data1 to HI (IDLE only)
- mtlo  input  1  write data1 to LO (IDLE only)
- busy  output  1  high from the edge accepting start until the edge that writes HI/LO
- done  output  1  one-cycle pulse; HI/LO hold the new result while it is high
- div_by_zero  output  1  one-cycle pulse coincident with done, for DIV/DIVU with data2==0
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; internal counter, operand and accumulator registers cleared. Asserting reset mid-operation aborts the operation immediately, with no HI/LO write. After release the unit is in IDLE.
- States: IDLE, CALC, FIN.
- IDLE, start=1:
  - Latch op and operand magnitudes (abs value for signed ops, raw for unsigned). Record result signs:
    - product sign = sign(data1) XOR sign(data2);
    - quotient sign = the same XOR;
    - remainder sign = sign(data1).
  - Set count=0 and busy=1.
  - For DIV/DIVU with data2==0, go to FIN directly. Otherwise go to CALC.
- IDLE, start=0: mthi writes HI<=data1 and mtlo writes LO<=data1; both may be high in the same cycle. If start=1 in the same cycle, start has priority and mthi/mtlo are ignored.
- CALC: one iteration per clock, count increments, and the state leaves CALC after XLEN iterations (count==XLEN-1 → FIN).
  - Multiply: shift-add on a 2*XLEN accumulator of magnitudes.
  - Divide: restoring shift-subtract producing magnitude quotient and remainder.
- FIN (one cycle): apply sign correction (two's-complement negate where the recorded sign is 1), then write the result on the exiting edge:
  - MULT/MULTU: {HI,LO} = 2*XLEN-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Divide by zero: HI=data1 as latched, LO=all ones, div_by_zero=1.
  - On the same edge: done=1, busy=0, state → IDLE.
- Latency: start sampled at edge E0 → CALC on E1..E_XLEN → FIN writes at E_(XLEN+1). For XLEN=32, done is high in the cycle after E33. Divide-by-zero writes at E2.
- done and div_by_zero are registered and clear on the next edge.
- start, mthi and mtlo are ignored while busy.
- A new start may be accepted in the cycle in which done is high, because the state is IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0, with no flag.
- Operand buses may change after the start edge; the result depends only on the values latched at start.
- HI/LO remain stable except on a FIN write, an IDLE mthi/mtlo write, or reset.

Test Plan:
- MULT data1=0xFFFFFFFD (-3), data2=7 → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=0x0000000E, hi=0x00000002. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → done and div_by_zero pulse together after E2; hi=0x12345678, lo=0xFFFFFFFF.
- Handshake and MTHI/MTLO:
  - A second start at cycle 10 of a busy MULT is ignored.
  - mtlo during busy is ignored; hi/lo are unchanged until FIN.
  - Back-to-back start on the done cycle is accepted.
  - mthi+mtlo with data1=0xA5A5A5A5 in IDLE sets both registers; with start=1 in the same cycle, only the operation runs.
- Reset: drop rst_n asynchronously in the middle of cycle 15 of a DIV → busy, done and hi/lo go to 0 immediately without waiting for a clock edge. After release, a fresh MULTU 3×5 gives lo=15, hi=0.
